imm_decode_stage: RTL

Pipelined, parametrised immediate-generation stage for the decode path. It accepts raw instruction words over a valid/ready handshake and produces the sign- or zero-extended immediate, its format class and a pass-through tag, registered, one cycle later. It supports XLEN 32 or 64, CSR zimm, and shift-amount extraction. A two-entry skid buffer gives full throughput under backpressure, and a synchronous flush supports branch redirect.

---
 rtl/imm_pkg.sv | 38 +++
 rtl/imm_decode_stage_if.sv | 32 +++
 rtl/imm_extract.sv | 97 +++++++++
 rtl/imm_decode_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-decode stage.
//   imm_type_t : 3-bit immediate class presented with each result
//   Op*        : major opcodes (inst[6:2]) that carry an immediate
//   F3*        : funct3 codes that turn OP-IMM into a shift
//   xlen_legal : true for the supported datapath widths
package imm_pkg;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5,
    ImmZ    = 3'd6,
    ImmSh   = 3'd7
  } imm_type_t;

  localparam logic [4:0] OpLoad    = 5'b00000;
  localparam logic [4:0] OpMiscMem = 5'b00011;
  localparam logic [4:0] OpOpImm   = 5'b00100;
  localparam logic [4:0] OpAuipc   = 5'b00101;
  localparam logic [4:0] OpOpImm32 = 5'b00110;
  localparam logic [4:0] OpStore   = 5'b01000;
  localparam logic [4:0] OpLui     = 5'b01101;
  localparam logic [4:0] OpBranch  = 5'b11000;
  localparam logic [4:0] OpJalr    = 5'b11001;
  localparam logic [4:0] OpJal     = 5'b11011;
  localparam logic [4:0] OpSystem  = 5'b11100;

  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Srx = 3'b101;

  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate-decode stage.
//   in_*  : instruction offer (valid/ready, raw word, tag)
//   out_* : registered result (valid/ready, immediate, class, tag)
// slave  : the stage side; master : the producer/consumer side.
interface imm_decode_stage_if
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type_t        out_type;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction from a raw instruction word.
//   i_inst : 32-bit instruction
//   o_imm  : immediate, sign- or zero-extended to XLEN
//   o_type : immediate class
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output imm_type_t       o_type
);

  logic [4:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_shift;
  logic [31:0] w_imm32;
  logic        w_sext;
  logic        w_unused;

  assign w_opcode   = i_inst[6:2];
  assign w_funct3   = i_inst[14:12];
  assign w_is_shift = (w_funct3 == F3Sll) || (w_funct3 == F3Srx);
  assign w_unused   = ^i_inst[1:0];

  always_comb begin
    w_imm32 = '0;
    w_sext  = 1'b1;
    o_type  = ImmNone;
    unique case (w_opcode)
      OpLui, OpAuipc: begin
        w_imm32 = {i_inst[31:12], 12'b0};
        o_type  = ImmU;
      end
      OpJal: begin
        w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
        o_type  = ImmJ;
      end
      OpBranch: begin
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
        o_type  = ImmB;
      end
      OpStore: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        o_type  = ImmS;
      end
      OpLoad, OpMiscMem, OpJalr: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        o_type  = ImmI;
      end
      OpOpImm: begin
        if (w_is_shift) begin
          // Shamt is 6 bits wide on RV64; the funct7 bits above it are dropped.
          w_imm32 = (XLEN == 64) ? {26'b0, i_inst[25:20]} : {27'b0, i_inst[24:20]};
          w_sext  = 1'b0;
          o_type  = ImmSh;
        end else begin
          w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
          o_type  = ImmI;
        end
      end
      OpOpImm32: begin
        // Word ops only exist on RV64; on RV32 this opcode carries no immediate.
        if (XLEN == 64) begin
          if (w_is_shift) begin
            w_imm32 = {27'b0, i_inst[24:20]};
            w_sext  = 1'b0;
            o_type  = ImmSh;
          end else begin
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            o_type  = ImmI;
          end
        end
      end
      OpSystem: begin
        if (w_funct3[2]) begin
          w_imm32 = {27'b0, i_inst[19:15]};
          w_sext  = 1'b0;
          o_type  = ImmZ;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_imm        = '0;
    o_imm[31:0]  = w_imm32;
    for (int i = 32; i < XLEN; i++) begin
      o_imm[i] = w_sext & w_imm32[31];
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (clears state and data)
//   flush : synchronous discard of all held entries
//   bus   : in_* instruction offer, out_* registered result
// Results appear one cycle after acceptance; in_ready is a flop so there is
// no combinational path from out_ready or in_* to any output.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  imm_decode_stage_if.slave  bus
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  w_ext_imm;
  imm_type_t        w_ext_type;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .i_inst (bus.in_inst),
    .o_imm  (w_ext_imm),
    .o_type (w_ext_type)
  );

  logic             r_out_valid, w_out_valid_d;
  logic [XLEN-1:0]  r_out_imm,   w_out_imm_d;
  imm_type_t        r_out_type,  w_out_type_d;
  logic [TAG_W-1:0] r_out_tag,   w_out_tag_d;
  logic             r_skid_valid, w_skid_valid_d;
  logic [XLEN-1:0]  r_skid_imm,   w_skid_imm_d;
  imm_type_t        r_skid_type,  w_skid_type_d;
  logic [TAG_W-1:0] r_skid_tag,   w_skid_tag_d;
  logic             r_in_ready;

  logic w_in_fire;
  logic w_out_free;

  assign w_in_fire  = bus.in_valid && r_in_ready;
  // OUT can take a new entry if it is empty or being consumed this cycle.
  assign w_out_free = !r_out_valid || bus.out_ready;

  always_comb begin
    w_out_valid_d  = r_out_valid;
    w_out_imm_d    = r_out_imm;
    w_out_type_d   = r_out_type;
    w_out_tag_d    = r_out_tag;
    w_skid_valid_d = r_skid_valid;
    w_skid_imm_d   = r_skid_imm;
    w_skid_type_d  = r_skid_type;
    w_skid_tag_d   = r_skid_tag;
    if (w_out_free) begin
      if (r_skid_valid) begin
        // in_ready was low, so no new accept can collide with this move.
        w_out_valid_d  = 1'b1;
        w_out_imm_d    = r_skid_imm;
        w_out_type_d   = r_skid_type;
        w_out_tag_d    = r_skid_tag;
        w_skid_valid_d = 1'b0;
      end else if (w_in_fire) begin
        w_out_valid_d  = 1'b1;
        w_out_imm_d    = w_ext_imm;
        w_out_type_d   = w_ext_type;
        w_out_tag_d    = bus.in_tag;
      end else begin
        w_out_valid_d  = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_valid_d = 1'b1;
      w_skid_imm_d   = w_ext_imm;
      w_skid_type_d  = w_ext_type;
      w_skid_tag_d   = bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_type   <= ImmNone;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_type  <= ImmNone;
      r_skid_tag   <= '0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_out_valid_d;
      r_out_imm    <= w_out_imm_d;
      r_out_type   <= w_out_type_d;
      r_out_tag    <= w_out_tag_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_imm   <= w_skid_imm_d;
      r_skid_type  <= w_skid_type_d;
      r_skid_tag   <= w_skid_tag_d;
      r_in_ready   <= !w_skid_valid_d;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_imm   = r_out_imm;
  assign bus.out_type  = r_out_type;
  assign bus.out_tag   = r_out_tag;

endmodule
